// File: rtl/alu_secuencial_if.sv
// rtl/alu_secuencial_if.sv - operand/opcode request and result/status bundle for alu_secuencial
interface alu_secuencial_if #(
    parameter int tamanioDato      = 8,
    parameter int tamanioOperacion = 8
);
    logic [tamanioDato-1:0]      operandoA;
    logic [tamanioDato-1:0]      operandoB;
    logic [tamanioOperacion-1:0] operacion;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic [tamanioDato-1:0]      resultado;
    logic [3:0]                  flags;
    logic                        op_invalida;

    modport master (
        output operandoA, operandoB, operacion, start,
        input  busy, done, resultado, flags, op_invalida
    );

    modport slave (
        input  operandoA, operandoB, operacion, start,
        output busy, done, resultado, flags, op_invalida
    );
endinterface

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - registered ALU with single-cycle ops and shift-and-add multi-cycle MUL
module alu_secuencial #(
    parameter int tamanioDato      = 8,
    parameter int tamanioOperacion = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_secuencial_if.slave bus
);
    localparam int N  = tamanioDato;
    localparam int CW = $clog2(tamanioDato) + 1;

    localparam logic [tamanioOperacion-1:0] OP_ADD = tamanioOperacion'(8'h20);
    localparam logic [tamanioOperacion-1:0] OP_SUB = tamanioOperacion'(8'h22);
    localparam logic [tamanioOperacion-1:0] OP_AND = tamanioOperacion'(8'h24);
    localparam logic [tamanioOperacion-1:0] OP_OR  = tamanioOperacion'(8'h25);
    localparam logic [tamanioOperacion-1:0] OP_XOR = tamanioOperacion'(8'h26);
    localparam logic [tamanioOperacion-1:0] OP_NOR = tamanioOperacion'(8'h27);
    localparam logic [tamanioOperacion-1:0] OP_SRL = tamanioOperacion'(8'h02);
    localparam logic [tamanioOperacion-1:0] OP_SRA = tamanioOperacion'(8'h03);
    localparam logic [tamanioOperacion-1:0] OP_SLL = tamanioOperacion'(8'h00);
    localparam logic [tamanioOperacion-1:0] OP_MUL = tamanioOperacion'(8'h18);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    localparam logic [N-1:0]  LIMITE = N'(tamanioDato);
    localparam logic [CW-1:0] ULTIMO = CW'(tamanioDato - 1);

    logic [0:0]     estado;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;

    logic           busy_r, done_r, inv_r;
    logic [N-1:0]   res_r;
    logic [3:0]     flags_r;

    logic [N:0]     suma, resta;
    logic [N-1:0]   res_c;
    logic           carry_c, ovf_c, inv_c, fuera;
    logic [3:0]     flags_c;

    always_comb begin
        suma    = {1'b0, bus.operandoA} + {1'b0, bus.operandoB};
        resta   = {1'b0, bus.operandoA} - {1'b0, bus.operandoB};
        fuera   = (bus.operandoB >= LIMITE);
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        inv_c   = 1'b0;
        case (bus.operacion)
            OP_ADD: begin
                res_c   = suma[N-1:0];
                carry_c = suma[N];
                ovf_c   = (bus.operandoA[N-1] == bus.operandoB[N-1]) && (suma[N-1] != bus.operandoA[N-1]);
            end
            OP_SUB: begin
                res_c   = resta[N-1:0];
                carry_c = resta[N];
                ovf_c   = (bus.operandoA[N-1] != bus.operandoB[N-1]) && (resta[N-1] != bus.operandoA[N-1]);
            end
            OP_AND: res_c = bus.operandoA & bus.operandoB;
            OP_OR:  res_c = bus.operandoA | bus.operandoB;
            OP_XOR: res_c = bus.operandoA ^ bus.operandoB;
            OP_NOR: res_c = ~(bus.operandoA | bus.operandoB);
            OP_SRL: if (!fuera) res_c = bus.operandoA >> bus.operandoB;
            OP_SLL: if (!fuera) res_c = bus.operandoA << bus.operandoB;
            OP_SRA: begin
                if (fuera) res_c = {N{bus.operandoA[N-1]}};
                else       res_c = $unsigned($signed(bus.operandoA) >>> bus.operandoB);
            end
            OP_MUL: res_c = '0;
            default: inv_c = 1'b1;
        endcase
        flags_c = {(res_c == '0), res_c[N-1], carry_c, ovf_c};
    end

    // One partial product per cycle: mcand walks left while mplier walks right.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado  <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            inv_r   <= 1'b0;
            res_r   <= '0;
            flags_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (estado)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.operacion == OP_MUL) begin
                            mcand  <= {{N{1'b0}}, bus.operandoA};
                            mplier <= bus.operandoB;
                            acc    <= '0;
                            cnt    <= '0;
                            busy_r <= 1'b1;
                            estado <= MUL;
                        end else begin
                            res_r   <= res_c;
                            flags_r <= flags_c;
                            inv_r   <= inv_c;
                            done_r  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == ULTIMO) begin
                        res_r   <= acc_next[N-1:0];
                        flags_r <= {(acc_next[N-1:0] == '0), acc_next[N-1], 1'b0, |acc_next[2*N-1:N]};
                        inv_r   <= 1'b0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        estado  <= IDLE;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.resultado   = res_r;
    assign bus.flags       = flags_r;
    assign bus.op_invalida = inv_r;
endmodule

// File: doc/alu_secuencial.md
ALU_SECUENCIAL -- requirements
Module: alu_secuencial

Interface
REQ-001 The block SHALL have parameter tamanioDato, default 8, giving the operand and result width in bits (>= 4).
REQ-002 The block SHALL have parameter tamanioOperacion, default 8, giving the opcode width in bits (>= 8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port operandoA, input, tamanioDato bits: operand A.
REQ-006 The block SHALL have port operandoB, input, tamanioDato bits: operand B, or the shift amount for shifts.
REQ-007 The block SHALL have port operacion, input, tamanioOperacion bits: the opcode.
REQ-008 The block SHALL have port start, input, 1 bit: request to execute; sampled only when busy=0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a multi-cycle MUL is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid resultado and new flags.
REQ-011 The block SHALL have port resultado, output, tamanioDato bits: registered result.
REQ-012 The block SHALL have port flags, output, 4 bits: registered status {zero, negativo, carry, overflow}, bits [3:0].
REQ-013 The block SHALL have port op_invalida, output, 1 bit: high together with done when the executed opcode is undefined.

Function
REQ-014 Opcodes SHALL be: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRL 0x02, SRA 0x03, SLL 0x00, MUL 0x18 (unsigned).
REQ-015 The FSM SHALL have two states: IDLE and MUL; reset enters IDLE.
REQ-016 In IDLE with start=1 and a non-MUL opcode, the edge sampling start SHALL register resultado, flags and op_invalida, and SHALL set done=1 for exactly the following cycle (latency 1); the state remains IDLE.
REQ-017 In IDLE with start=1 and opcode MUL, the block SHALL latch operandoA/operandoB, clear the accumulator, set busy=1 and enter MUL.
REQ-018 MUL SHALL run shift-and-add, one bit of B per cycle, with a counter of clog2(tamanioDato)+1 bits, completing after tamanioDato cycles: done=1 and busy=0 in the cycle after the last iteration; return to IDLE.
REQ-019 Back-to-back operation SHALL be supported: start may be asserted in the same cycle done is high, if busy=0.
REQ-020 start while busy=1 SHALL be ignored; operand and opcode changes during MUL SHALL NOT affect the result.
REQ-021 ADD/SUB SHALL use tamanioDato+1-bit arithmetic: carry = carry-out for ADD, borrow (A<B unsigned) for SUB; overflow = two's-complement signed overflow.
REQ-022 Shifts SHALL use all of operandoB as the amount: SRL/SLL with amount >= tamanioDato give 0; SRA with amount >= tamanioDato gives all sign bits.
REQ-023 MUL SHALL return the low tamanioDato bits of the 2*tamanioDato product; overflow=1 iff the upper half is non-zero; carry=0.
REQ-024 Logic ops and shifts SHALL set carry=0 and overflow=0.
REQ-025 zero SHALL be 1 iff resultado==0; negativo SHALL equal resultado MSB; both apply to every opcode.
REQ-026 An undefined opcode SHALL complete as a single-cycle op with resultado=0, flags=4'b1000 and op_invalida=1.
REQ-027 resultado, flags and op_invalida SHALL hold their value until the next completion; done SHALL be 0 otherwise.

Reset
REQ-028 With reset_n=0 at a rising edge, the block SHALL enter IDLE and set busy=0, done=0, resultado=0, flags=0, op_invalida=0, and clear the counter and accumulator.
REQ-029 Reset during MUL SHALL abort the operation, with no done pulse afterwards; reset has priority over start.

Verification (tamanioDato=8)
REQ-030 The bench SHALL apply ADD A=0x7F B=0x01 start -> next cycle done=1, resultado=0x80, flags=0101 (neg, ovf).
REQ-031 The bench SHALL apply SUB A=0x00 B=0x01 -> resultado=0xFF, flags=0110; and ADD 0xFF+0x01 -> resultado=0x00, flags=1010.
REQ-032 The bench SHALL apply SRA A=0x80 B=2 -> 0xE0; SRA A=0x80 B=9 -> 0xFF; SLL A=0x01 B=8 -> 0x00 with zero=1.
REQ-033 The bench SHALL apply MUL A=0x0F B=0x11 -> busy for 8 cycles, then done with 0xFF and ovf=0; MUL 0x10*0x10 -> 0x00, flags=1001; start pulses during busy are ignored.
REQ-034 The bench SHALL assert reset_n=0 at cycle 4 of a MUL -> all outputs 0, no done; a following ADD 0x02+0x03 -> 0x05 with latency 1.
REQ-035 The bench SHALL apply opcode 0xFF -> done=1, op_invalida=1, resultado=0x00, flags=1000; then back-to-back ADD in the done cycle completes on the next cycle.
